// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: decodes the start/stop FSM state into a run enable, prescales
// userclock into centisecond ticks and keeps an MM:SS.cc BCD time for the display mux.
module stopwatch_timebase #(
  parameter int TICK_DIV = 500000,
  parameter int PRESC_W  = 19
) (
  input  logic       userclock,
  input  logic       resetn,
  input  logic [1:0] state,
  input  logic       clear,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic [1:0] {
    ST_PAUSED      = 2'd0,
    ST_RUN_HELD    = 2'd1,
    ST_RUN         = 2'd2,
    ST_PAUSE_HELD  = 2'd3
  } sw_state_e;

  localparam int NUM_DIGITS = 6;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]          presc_q, presc_d;
  logic [NUM_DIGITS-1:0][3:0]  digit_q, digit_d;
  logic                        running_q;
  logic                        tick_q, tick_d;
  logic                        wrap_q, wrap_d;

  logic                        run_en;
  logic                        advance;
  logic                        clear_digits;
  logic [NUM_DIGITS-1:0]       at_limit;
  logic [NUM_DIGITS:0]         carry;

  // Run decode is combinational so a pause on the terminal-count edge suppresses the tick.
  assign run_en = (sw_state_e'(state) == ST_RUN_HELD) || (sw_state_e'(state) == ST_RUN);

  always_comb begin
    presc_d      = presc_q;
    advance      = 1'b0;
    clear_digits = 1'b0;
    if (run_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        advance = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (clear) begin
      presc_d      = '0;
      clear_digits = 1'b1;
    end
  end

  always_comb begin
    carry    = '0;
    carry[0] = advance;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      carry[i+1] = carry[i] & at_limit[i];
    end
  end

  // Digit order from index 0: cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam logic [3:0] LIMIT = ((gi == 3) || (gi == 5)) ? 4'd5 : 4'd9;
      assign at_limit[gi] = (digit_q[gi] >= LIMIT);
      assign digit_d[gi]  = clear_digits ? 4'd0 :
                            carry[gi]    ? (at_limit[gi] ? 4'd0 : digit_q[gi] + 4'd1) :
                                           digit_q[gi];
    end
  endgenerate

  assign tick_d = advance;
  assign wrap_d = carry[NUM_DIGITS];

  always_ff @(posedge userclock or negedge resetn) begin
    if (!resetn) begin
      presc_q   <= '0;
      digit_q   <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      running_q <= run_en;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign cs_ones  = digit_q[0];
  assign cs_tens  = digit_q[1];
  assign sec_ones = digit_q[2];
  assign sec_tens = digit_q[3];
  assign min_ones = digit_q[4];
  assign min_tens = digit_q[5];
  assign running  = running_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Bench for stopwatch_timebase: a total-centiseconds model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_stopwatch_timebase;

  localparam int TICK_DIV    = 4;
  localparam int PRESC_W     = 3;
  localparam int CS_PER_HOUR = 360000;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] state;
  logic       clear;
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic       running, tick, wrap;

  int tests_run = 0;
  int failed    = 0;

  int m_total = 0;
  int m_phase = 0;
  logic m_run = 1'b0, m_tick = 1'b0, m_wrap = 1'b0;
  logic preload_req = 1'b0;
  int   preload_val = 0;

  stopwatch_timebase #(.TICK_DIV(TICK_DIV), .PRESC_W(PRESC_W)) dut (
    .userclock(clk), .resetn(resetn), .state(state), .clear(clear),
    .cs_ones(cs_ones), .cs_tens(cs_tens), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] bcd_time(input int t);
    int cs, s, m;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = t / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic logic [23:0] dut_time();
    return {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: time kept as total centiseconds within the hour; phase counts cycles into the current centisecond.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_total <= 0;
      m_phase <= 0;
      m_run   <= 1'b0;
      m_tick  <= 1'b0;
      m_wrap  <= 1'b0;
    end else begin
      m_run  <= (state == 2'd1) || (state == 2'd2);
      m_tick <= 1'b0;
      m_wrap <= 1'b0;
      if (preload_req) begin
        m_total <= preload_val;
      end else if ((state == 2'd1) || (state == 2'd2)) begin
        if (m_phase == TICK_DIV - 1) begin
          m_phase <= 0;
          m_total <= (m_total + 1) % CS_PER_HOUR;
          m_tick  <= 1'b1;
          m_wrap  <= (m_total == CS_PER_HOUR - 1);
        end else begin
          m_phase <= m_phase + 1;
        end
      end else if (clear) begin
        m_total <= 0;
        m_phase <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cycle", {5'd0, dut_time(), running, tick, wrap},
                   {5'd0, bcd_time(m_total), m_run, m_tick, m_wrap});
  end

  initial begin
    resetn = 1'b0;
    state  = 2'd0;
    clear  = 1'b0;
    cycles(3);
    check("reset_state", {5'd0, dut_time(), running, tick, wrap}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    state = 2'd2;

    // Steady run: tick on every 4th cycle, 10 ticks in 40 cycles.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("a_tick", {31'd0, tick}, {31'd0, (k % 4) == 0});
      if (k == 1) check("a_running_lag", {31'd0, running}, 32'd1);
    end
    check("a_time_40", {8'd0, dut_time()}, 32'h000010);

    // Pause mid-centisecond, then resume: partial count is kept.
    cycles(2);
    state = 2'd0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("b_pause_tick", {31'd0, tick}, 32'd0);
      check("b_pause_time", {8'd0, dut_time()}, 32'h000010);
    end
    state = 2'd2;
    @(negedge clk);
    check("b_resume_1", {31'd0, tick}, 32'd0);
    @(negedge clk);
    check("b_resume_2", {31'd0, tick}, 32'd1);
    check("b_resume_time", {8'd0, dut_time()}, 32'h000011);

    // Run to 00:59.99, then one more tick carries into minutes.
    cycles(5988 * TICK_DIV);
    check("c_time_5999", {8'd0, dut_time()}, 32'h005999);
    cycles(TICK_DIV);
    check("c_time_min", {8'd0, dut_time()}, 32'h010000);
    check("c_tick", {31'd0, tick}, 32'd1);
    check("c_no_wrap", {31'd0, wrap}, 32'd0);

    // Preload 59:59.99 while paused, then roll over.
    state = 2'd0;
    @(negedge clk);
    #1;
    force dut.digit_q = 24'h595999;
    preload_val = CS_PER_HOUR - 1;
    preload_req = 1'b1;
    @(negedge clk);
    check("d_preload", {8'd0, dut_time()}, 32'h595999);
    #1;
    release dut.digit_q;
    preload_req = 1'b0;
    state = 2'd2;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("d_tick", {31'd0, tick}, {31'd0, i == 4});
      check("d_wrap", {31'd0, wrap}, {31'd0, i == 4});
    end
    check("d_wrap_time", {8'd0, dut_time()}, 32'd0);
    @(negedge clk);
    check("d_wrap_once", {30'd0, tick, wrap}, 32'd0);

    // clear ignored while running, effective while paused.
    cycles(147);
    check("e_time_37", {8'd0, dut_time()}, 32'h000037);
    clear = 1'b1;
    cycles(TICK_DIV);
    check("e_clear_ignored", {8'd0, dut_time()}, 32'h000038);
    state = 2'd3;
    @(negedge clk);
    check("e_cleared", {5'd0, dut_time(), running, tick, wrap}, 32'd0);
    @(negedge clk);
    check("e_clear_held", {8'd0, dut_time()}, 32'd0);
    clear = 1'b0;
    state = 2'd2;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("e_presc_zero", {31'd0, tick}, {31'd0, i == 4});
    end
    check("e_time_1", {8'd0, dut_time()}, 32'h000001);

    // Asynchronous reset mid-count at 00:12.45.
    cycles(1244 * TICK_DIV);
    check("f_time_1245", {8'd0, dut_time()}, 32'h001245);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("f_async_reset", {5'd0, dut_time(), running, tick, wrap}, 32'd0);
    state = 2'd1;
    cycles(2);
    resetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("f_first_tick", {31'd0, tick}, {31'd0, i == 4});
    end
    check("f_time_1", {8'd0, dut_time()}, 32'h000001);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
